spi_master_arbiter: RTL
=======================

# spi_master_arbiter

Round-robin arbiter and transaction sequencer sharing one SPI byte master among NREQ requesters. Each requester posts a one-byte transfer (slave address, TX byte, clock polarity, clock divider select). The block grants one requester at a time, drives the master's configuration and start strobe, waits for the master's busy handshake, and returns the received byte with a per-requester done pulse. It sits between the SPI master and the internal logic blocks that need SPI access.

## Interface
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 1023, cycles allowed from start to master done (1..65535; used only with SPI_ARB_TIMEOUT_EN)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  request per requester, level
- req_addr  in  4*NREQ  slave address, requester i at [4i+3:4i]
- req_wdata  in  8*NREQ  TX byte, requester i at [8i+7:8i]
- req_cpol  in  NREQ  clock polarity per requester
- req_clk_sel  in  3*NREQ  clock divider select, requester i at [3i+2:3i]
- gnt  out  NREQ  one-cycle grant pulse, one-hot
- done  out  NREQ  one-cycle completion pulse, one-hot
- rdata  out  8  received byte, valid while done is high, held until the next done
- err  out  1  one-cycle timeout pulse
- m_start  out  1  one-cycle start strobe to the master
- m_addr, m_wdata, m_cpol, m_clk_sel  out  4/8/1/3  registered transfer fields to the master
- m_busy  in  1  master busy
- m_rdata  in  8  master received byte

## Operation
- States: IDLE, ACK, RUN.
- IDLE: if any req bit is set and m_busy=0, select winner w by round robin.
  - Search starts at ptr and runs ptr, ptr+1, … with wrap-around modulo NREQ.
  - Register w's fields onto m_*.
  - Set gnt[w]=1 and m_start=1 for one cycle.
  - Go to ACK.
- If m_busy=1 in IDLE, no grant is issued. This covers a master left busy by reset or by an external user.
- ACK: gnt and m_start are 0. Wait for m_busy=1, then go to RUN.
- RUN: wait for m_busy=0. Then:
  - rdata<=m_rdata
  - done[w]=1 for one cycle
  - ptr<=(w+1) mod NREQ
  - go to IDLE
- m_* fields hold their value from grant until the next grant.
- Requester rules:
  - Hold req and fields stable until gnt.
  - Deassert req or present the next byte in the cycle after gnt.
  - A req dropped before grant is not served.
  - A req dropped after grant does not abort the transfer.
- Simultaneous requests: exactly one grant is issued. A requester cannot win twice while another is waiting.
- Reset values: state IDLE, ptr 0, gnt 0, done 0, rdata 8'h00, err 0, m_start 0, m_addr 0, m_wdata 0, m_cpol 0, m_clk_sel 0.
- Reset mid-transfer: outputs return to reset values immediately. The in-flight transfer is dropped with no done pulse. The next grant waits for m_busy=0.

## Timing
- req seen in IDLE at edge n: gnt and m_start are high during cycle n+1.
- m_busy falls, sampled at edge k: done and rdata are valid during cycle k+1.
- Arbitration runs in the same IDLE cycle as done, so back-to-back grants are spaced by one cycle after done.
- Minimum transaction: grant + 1 cycle in ACK + master duration + 1 cycle.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears at grant and increments each cycle in ACK and RUN.
  - When the count reaches TIMEOUT: err=1 and done[w]=1 for one cycle, rdata<=8'hFF, ptr advances, state goes to IDLE.
  - A late m_busy fall from the aborted transfer is ignored, because IDLE only watches the m_busy level.
- Not defined: no counter; err is tied to 0; ACK and RUN wait indefinitely.

## Test plan
- Single transfer:
  - Stimulus: req[2]=1, addr 4'h5, wdata 8'hA5, cpol 1, clk_sel 3; master model goes busy 2 cycles after start for 20 cycles and returns 8'h3C.
  - Required: gnt[2] one cycle after req; m_addr=5, m_wdata=A5, m_cpol=1, m_clk_sel=3; done[2] and rdata=8'h3C one cycle after busy falls.
- Round-robin fairness:
  - Stimulus: req=4'b1111 held continuously.
  - Required: grant order 0,1,2,3,0; never two gnt bits set.
- Wrap-around:
  - Stimulus: after serving 3, assert req=4'b1001.
  - Required: 0 is granted before 3.
- Busy at idle:
  - Stimulus: hold m_busy=1 with req[1]=1.
  - Required: no gnt; gnt[1] one cycle after m_busy drops.
- Reset in RUN:
  - Stimulus: assert rst=0 in RUN.
  - Required: all outputs at reset values in the same cycle; no done pulse; after release, grant withheld until m_busy=0.
- Timeout (SPI_ARB_TIMEOUT_EN, TIMEOUT=50):
  - Stimulus: master never asserts busy.
  - Required: err and done pulse exactly 50 cycles after grant; rdata=8'hFF.

Source files
------------

// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter: round-robin arbiter sequencing one-byte transfers from NREQ requesters onto a shared SPI master.
// Define SPI_ARB_TIMEOUT_EN to abort transfers that exceed TIMEOUT cycles (err pulse, rdata 8'hFF).
module spi_master_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [4*NREQ-1:0] req_addr,
   input  logic [8*NREQ-1:0] req_wdata,
   input  logic [NREQ-1:0]   req_cpol,
   input  logic [3*NREQ-1:0] req_clk_sel,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [7:0]        rdata,
   output logic              err,
   output logic              m_start,
   output logic [3:0]        m_addr,
   output logic [7:0]        m_wdata,
   output logic              m_cpol,
   output logic [2:0]        m_clk_sel,
   input  logic              m_busy,
   input  logic [7:0]        m_rdata
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, ACK, RUN} state_t;
   state_t state, nxt;
   logic [PW-1:0] ptr, w, win, j;
   logic found, grant, fin, to;
   logic [3:0] a_arr [NREQ];
   logic [7:0] w_arr [NREQ];
   logic [2:0] s_arr [NREQ];
   genvar i;
   generate
      for (i = 0; i < NREQ; i++) begin : g_unpack
         assign a_arr[i] = req_addr[4*i +: 4];
         assign w_arr[i] = req_wdata[8*i +: 8];
         assign s_arr[i] = req_clk_sel[3*i +: 3];
      end
   endgenerate
   // First requesting index at or after ptr, wrapping modulo NREQ
   always_comb begin
      found = 1'b0;
      win = ptr;
      j = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = PW'((int'(ptr) + k) % NREQ);
         if (!found && req[j]) begin
            found = 1'b1;
            win = j;
         end
      end
      nxt = state;
      case (state)
         IDLE:    nxt = (found && !m_busy) ? ACK : IDLE;
         ACK:     nxt = to ? IDLE : m_busy ? RUN : ACK;
         RUN:     nxt = (!m_busy || to) ? IDLE : RUN;
         default: nxt = IDLE;
      endcase
   end
   assign grant = state == IDLE && found && !m_busy;
   assign fin = state == RUN && !m_busy;
`ifdef SPI_ARB_TIMEOUT_EN
   logic [15:0] cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else cnt <= grant ? '0 : (state != IDLE) ? cnt + 16'd1 : cnt;
   assign to = state != IDLE && cnt == 16'(TIMEOUT - 1) && !fin;
`else
   assign to = TIMEOUT < 0;
`endif
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr <= '0;
         w <= '0;
         gnt <= '0;
         done <= '0;
         rdata <= 8'h00;
         err <= 1'b0;
         m_start <= 1'b0;
         m_addr <= '0;
         m_wdata <= '0;
         m_cpol <= 1'b0;
         m_clk_sel <= '0;
      end else begin
         state <= nxt;
         gnt <= grant ? NREQ'(1) << win : '0;
         m_start <= grant;
         done <= (fin || to) ? NREQ'(1) << w : '0;
         err <= to;
         if (grant) begin
            w <= win;
            m_addr <= a_arr[win];
            m_wdata <= w_arr[win];
            m_cpol <= req_cpol[win];
            m_clk_sel <= s_arr[win];
         end
         if (fin || to) begin
            rdata <= fin ? m_rdata : 8'hFF;
            ptr <= (w == PW'(NREQ - 1)) ? '0 : w + 1'b1;
         end
      end
   end
endmodule
